sequence_detector_core: RTL and testbench
=========================================

SEQUENCE_DETECTOR_CORE -- requirements
Module: sequence_detector

Interface
REQ-001 Parameters: none; pattern, width and bit order are fixed by this spec.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 switches  input  11  bit 10 = enable (scan request); bits 9:0 = 10-bit data word to scan.
REQ-005 out  output  4  registered count of "101" occurrences found in the last completed scan, unsigned.

Function
REQ-006 Control FSM SHALL have exactly three states: IDLE, SCAN, DONE.
REQ-007 IDLE: if switches[10]=1 at a rising edge, the block SHALL capture switches[9:0] into an internal 10-bit word, clear the internal match count to 0, set the bit index to 9, reset the detector to S0, and go to SCAN; otherwise it SHALL stay in IDLE.
REQ-008 SCAN: each cycle the block SHALL feed one captured bit to the detector, MSB first (index 9 down to 0), then decrement the index.
REQ-009 Detector sub-FSM SHALL use states S0 (no prefix), S1 (seen "1"), S10 (seen "10").
REQ-010 Transitions: S0 on 1 goes to S1, on 0 stays in S0. S1 on 1 stays in S1, on 0 goes to S10. S10 on 1 goes to S1 and increments the count, on 0 goes to S0.
REQ-011 Detection SHALL be overlapping: the final "1" of a match starts the next candidate.
REQ-012 Match count SHALL be 4 bits; the maximum possible value is 4, so no saturation or wrap logic is required.
REQ-013 On the edge that processes index 0, the FSM SHALL go to DONE and load out with the final count, including any match on bit 0.
REQ-014 out SHALL therefore update exactly 11 rising edges after the first edge that sees enable=1 in IDLE.
REQ-015 DONE: out SHALL hold its value; the FSM SHALL stay in DONE while switches[10]=1 and return to IDLE on the first edge with switches[10]=0.
REQ-016 A new scan SHALL require enable to be low for at least one edge after DONE; holding enable high SHALL NOT retrigger.
REQ-017 Changes on switches[9:0] after capture SHALL be ignored until the next scan starts.
REQ-018 Enable dropping during SCAN SHALL abort the scan: the FSM returns to IDLE on that edge, and out keeps its previous value.
REQ-019 out SHALL change only on SCAN-to-DONE and on reset; it SHALL retain its value through IDLE.

Reset
REQ-020 rst=1 at a rising edge SHALL force IDLE and detector S0, and clear out, the count, the index and the captured word to 0.
REQ-021 Reset SHALL take priority over all other inputs, including in the middle of SCAN.
REQ-022 After rst is released with enable still high, a fresh scan SHALL start on the first edge with rst=0.

Verification
REQ-023 Hold rst, then release with switches=11'b1_1010101010 held: out=0 for the first 10 edges after release, then out=4 from edge 11, held.
REQ-024 From DONE, enable=0 for 5 cycles, then switches=11'b1_1100110011: out stays 4 until the new scan completes, then becomes 0.
REQ-025 Assert rst for 2 cycles while enable=1 with data 1100110011, then release: out=0 during reset; after 11 edges out=0, FSM in DONE.
REQ-026 Data 0000000101: out=1. Data 1011011010: out=3. Data 0000000000: out=0. Each result appears after 11 edges.
REQ-027 Drop enable at scan cycle 5: FSM returns to IDLE and out keeps its prior value. Change switches[9:0] mid-scan: result reflects the captured word only.

Source files
------------

// File: rtl/sequence_detector_core.sv
// Scans a captured 10-bit word MSB first and counts overlapping "101" matches.
// The count is published on out when the scan completes; an abort leaves out untouched.
`timescale 1ns/1ps

module sequence_detector_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] switches,
  output logic [3:0]  out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    S0  = 2'd0,
    S1  = 2'd1,
    S10 = 2'd2
  } det_e;

  state_e     state_q, state_d;
  det_e       det_q, det_d;
  det_e       det_next_s;
  logic [9:0] word_q, word_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] count_q, count_d;
  logic [3:0] out_q, out_d;
  logic       enable_s;
  logic       bit_s;
  logic       match_s;
  logic [3:0] count_inc_s;

  assign enable_s    = switches[10];
  assign bit_s       = word_q[idx_q];
  assign count_inc_s = count_q + {3'b000, match_s};
  assign out         = out_q;

  // State register: reset dominates everything, including a scan in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      det_q   <= S0;
      word_q  <= 10'd0;
      idx_q   <= 4'd0;
      count_q <= 4'd0;
      out_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      det_q   <= det_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      out_q   <= out_d;
    end
  end

  // Detector step: the trailing 1 of a match leaves us in S1, giving overlap
  always_comb begin
    det_next_s = S0;
    match_s    = 1'b0;
    case (det_q)
      S0: begin
        if (bit_s) begin
          det_next_s = S1;
        end else begin
          det_next_s = S0;
        end
      end
      S1: begin
        if (bit_s) begin
          det_next_s = S1;
        end else begin
          det_next_s = S10;
        end
      end
      S10: begin
        if (bit_s) begin
          det_next_s = S1;
          match_s    = 1'b1;
        end else begin
          det_next_s = S0;
        end
      end
      default: begin
        det_next_s = S0;
        match_s    = 1'b0;
      end
    endcase
  end

  // Control next-state: DONE needs enable low once before another scan
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable_s) begin
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (!enable_s) begin
          state_d = IDLE;
        end else if (idx_q == 4'd0) begin
          state_d = DONE;
        end else begin
          state_d = SCAN;
        end
      end
      DONE: begin
        if (enable_s) begin
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath/output: capture on start, shift through bits, publish on the last bit
  always_comb begin
    det_d   = det_q;
    word_d  = word_q;
    idx_d   = idx_q;
    count_d = count_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (enable_s) begin
          word_d  = switches[9:0];
          count_d = 4'd0;
          idx_d   = 4'd9;
          det_d   = S0;
        end else begin
          word_d  = word_q;
          count_d = count_q;
        end
      end
      SCAN: begin
        if (enable_s) begin
          det_d   = det_next_s;
          count_d = count_inc_s;
          if (idx_q == 4'd0) begin
            idx_d = 4'd0;
            out_d = count_inc_s;
          end else begin
            idx_d = idx_q - 4'd1;
            out_d = out_q;
          end
        end else begin
          det_d   = det_q;
          count_d = count_q;
        end
      end
      DONE: begin
        out_d = out_q;
      end
      default: begin
        out_d = out_q;
      end
    endcase
  end

endmodule

// File: tb/tb_sequence_detector_core.sv
// Directed bench: the stimulus pushes the hand-computed out value expected after
// each edge; a monitor pops and compares just after every rising edge.
`timescale 1ns/1ps

module tb_sequence_detector_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] switches = 11'd0;
  logic [3:0]  out;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  sequence_detector_core dut (
    .clk      (clk),
    .rst      (rst),
    .switches (switches),
    .out      (out)
  );

  // Drive one edge's inputs and record what out must read after that edge.
  task automatic step(input logic r, input logic [10:0] sw, input logic [3:0] e);
    @(negedge clk);
    rst      = r;
    switches = sw;
    exp_q.push_back(e);
  endtask

  // Full scan with enable held: capture edge + 9 edges hold prev, 11th edge shows res.
  task automatic scan(input logic [9:0] d, input logic [3:0] prev, input logic [3:0] res);
    for (int i = 0; i < 10; i++) step(1'b0, {1'b1, d}, prev);
    step(1'b0, {1'b1, d}, res);
  endtask

  initial begin : monitor
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      edge_n++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (out !== e) begin
          n_fail++;
          $display("FAIL out_check edge %0d: got %0d expected %0d", edge_n, out, e);
        end
      end
    end
  end

  initial begin : stimulus
    // Reset with enable and data already present, then scan starts on release
    for (int i = 0; i < 3; i++) step(1'b1, {1'b1, 10'b1010101010}, 4'd0);
    scan(10'b1010101010, 4'd0, 4'd4);
    // Holding enable in DONE must not retrigger, even with new data
    for (int i = 0; i < 14; i++) step(1'b0, {1'b1, 10'b0000000101}, 4'd4);
    for (int i = 0; i < 5; i++) step(1'b0, {1'b0, 10'b1100110011}, 4'd4);
    scan(10'b1100110011, 4'd4, 4'd0);

    step(1'b0, {1'b0, 10'd0}, 4'd0);
    scan(10'b0000000101, 4'd0, 4'd1);
    step(1'b0, {1'b0, 10'd0}, 4'd1);
    scan(10'b1011011010, 4'd1, 4'd3);
    step(1'b0, {1'b0, 10'd0}, 4'd3);
    scan(10'b0000000000, 4'd3, 4'd0);
    step(1'b0, {1'b0, 10'd0}, 4'd0);
    scan(10'b1011011010, 4'd0, 4'd3);
    step(1'b0, {1'b0, 10'd0}, 4'd3);

    // Abort: enable drops at scan cycle 5, out keeps 3 and no late result appears
    for (int i = 0; i < 5; i++) step(1'b0, {1'b1, 10'b0000000101}, 4'd3);
    for (int i = 0; i < 8; i++) step(1'b0, {1'b0, 10'b0000000101}, 4'd3);

    // Data changes after capture: result follows the captured 0000000101 only
    step(1'b0, {1'b1, 10'b0000000101}, 4'd3);
    for (int i = 0; i < 9; i++) step(1'b0, {1'b1, 10'b1010101010}, 4'd3);
    step(1'b0, {1'b1, 10'b1010101010}, 4'd1);
    step(1'b0, {1'b0, 10'd0}, 4'd1);

    // Reset for 2 cycles mid-scan with enable high, fresh scan on release
    for (int i = 0; i < 4; i++) step(1'b0, {1'b1, 10'b1100110011}, 4'd1);
    for (int i = 0; i < 2; i++) step(1'b1, {1'b1, 10'b1100110011}, 4'd0);
    scan(10'b1100110011, 4'd0, 4'd0);
    for (int i = 0; i < 2; i++) step(1'b0, {1'b1, 10'b1010101010}, 4'd0);

    // Reset mid-scan then a nonzero fresh result, then reset out of DONE
    step(1'b0, {1'b0, 10'd0}, 4'd0);
    for (int i = 0; i < 4; i++) step(1'b0, {1'b1, 10'b1010101010}, 4'd0);
    step(1'b1, {1'b1, 10'b1010101010}, 4'd0);
    scan(10'b1010101010, 4'd0, 4'd4);
    step(1'b1, {1'b0, 10'd0}, 4'd0);
    step(1'b0, {1'b0, 10'd0}, 4'd0);

    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
